inst_rom_loader: RTL and testbench

- Instruction-memory responder for the core's fetch port (chip-enable, address, data) and the opposite end of the core's fetch initiator.
- Returns the instruction word in the same cycle, ahead of the IF/ID register.
- Provides a byte-stream load port with a valid/ready handshake that fills the memory after reset.
- Holds the core in reset while a program image is being loaded.

---
 rtl/inst_rom_loader_pkg.sv | 29 ++
 rtl/inst_rom_loader_if.sv | 31 +++
 rtl/inst_rom_loader_word_packer.sv | 45 ++++
 rtl/inst_rom_loader.sv | 118 +++++++++++
 tb/tb_inst_rom_loader.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/inst_rom_loader_pkg.sv
// Shared types and constants for the instruction ROM loader.
package inst_rom_loader_pkg;

   // Bus widths of the core's fetch port.
   localparam int REG_BUS_W       = 32;
   localparam int INST_ADDR_BUS_W = 32;

   // Word returned whenever a fetch is not served from the loaded image.
   localparam logic [REG_BUS_W-1:0] NOP_WORD = 32'h0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Position a byte inside a 32-bit word according to its index in the
   // stream; big-endian order puts the first byte in bits [31:24].
   function automatic logic [REG_BUS_W-1:0] place_byte(input logic [7:0] b,
                                                       input logic [1:0] idx,
                                                       input bit big);
      logic [1:0] lane;
      logic [4:0] sh;
      lane = big ? (2'd3 - idx) : idx;
      sh   = {lane, 3'b000};
      return {24'h0, b} << sh;
   endfunction

endpackage

// File: rtl/inst_rom_loader_if.sv
// Fetch port and byte-stream load port of the instruction ROM loader.
interface inst_rom_loader_if
   import inst_rom_loader_pkg::*;
#(
   parameter int ADDR_W = 10
);
   logic                       ce_i;
   logic [INST_ADDR_BUS_W-1:0] addr_i;
   logic [REG_BUS_W-1:0]       data_o;
   logic                       ld_start_i;
   logic                       ld_valid_i;
   logic [7:0]                 ld_byte_i;
   logic                       ld_last_i;
   logic                       ld_ready_o;
   logic                       core_hold_o;
   logic                       ld_done_o;
   logic                       ld_err_o;
   logic [ADDR_W:0]            words_o;

   // The ROM side of the link.
   modport slave (
      input  ce_i, addr_i, ld_start_i, ld_valid_i, ld_byte_i, ld_last_i,
      output data_o, ld_ready_o, core_hold_o, ld_done_o, ld_err_o, words_o
   );

   // The core / image-source side of the link.
   modport master (
      output ce_i, addr_i, ld_start_i, ld_valid_i, ld_byte_i, ld_last_i,
      input  data_o, ld_ready_o, core_hold_o, ld_done_o, ld_err_o, words_o
   );
endinterface

// File: rtl/inst_rom_loader_word_packer.sv
// Byte-to-word assembler: collects stream bytes into 32-bit words and
// flags when a complete (or final, zero-padded) word is ready to write.
module inst_word_packer
   import inst_rom_loader_pkg::*;
#(
   parameter bit BYTE_ORDER_BIG = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear_i,
   input  logic                 accept_i,
   input  logic [7:0]           byte_i,
   input  logic                 last_i,
   output logic [REG_BUS_W-1:0] word_o,
   output logic                 word_valid_o
);
   logic [REG_BUS_W-1:0] shreg_q, shreg_d;
   logic [1:0]           idx_q, idx_d;

   // Merge the incoming byte into the partial word and advance the lane index.
   always_comb begin
      shreg_d      = shreg_q;
      idx_d        = idx_q;
      word_o       = shreg_q | place_byte(byte_i, idx_q, BYTE_ORDER_BIG);
      word_valid_o = accept_i && ((idx_q == 2'd3) || last_i);
      if (clear_i) begin
         shreg_d = '0;
         idx_d   = 2'd0;
      end else if (accept_i) begin
         idx_d   = idx_q + 2'd1;
         shreg_d = word_valid_o ? '0 : word_o;
      end
   end

   // Partial-word and lane-index registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg_q <= '0;
         idx_q   <= 2'd0;
      end else begin
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
      end
   end
endmodule

// File: rtl/inst_rom_loader.sv
// Instruction memory for the core's fetch port, filled from a byte stream
// after reset while the core is held in reset.
module inst_rom_loader
   import inst_rom_loader_pkg::*;
#(
   parameter int ADDR_W         = 10,
   parameter bit BYTE_ORDER_BIG = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   inst_rom_loader_if.slave   bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   state_e               state_q, state_d;
   logic [ADDR_W:0]      words_q, words_d;
   logic                 err_q, err_d;
   logic                 ready;
   logic                 accept;
   logic                 clear;
   logic                 mem_we;
   logic                 word_valid;
   logic [REG_BUS_W-1:0] pack_word;
   logic [ADDR_W-1:0]    rd_idx;
   logic [REG_BUS_W-1:0] rd_data;
   logic                 addr_lsb_unused;
   logic [REG_BUS_W-1:0] mem [DEPTH];

   assign ready  = (state_q == ST_LOAD) && !err_q;
   // A restart in the same cycle wins over the byte on the bus.
   assign accept = bus.ld_valid_i && ready && !bus.ld_start_i;

   inst_word_packer #(.BYTE_ORDER_BIG(BYTE_ORDER_BIG)) u_packer (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (clear),
      .accept_i     (accept),
      .byte_i       (bus.ld_byte_i),
      .last_i       (bus.ld_last_i),
      .word_o       (pack_word),
      .word_valid_o (word_valid)
   );

   // Load sequencing: start/restart, word writes, overflow and completion.
   always_comb begin
      state_d = state_q;
      words_d = words_q;
      err_d   = err_q;
      clear   = 1'b0;
      mem_we  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.ld_start_i) begin
               state_d = ST_LOAD;
               words_d = '0;
               err_d   = 1'b0;
               clear   = 1'b1;
            end
         end
         ST_LOAD: begin
            if (bus.ld_start_i) begin
               words_d = '0;
               err_d   = 1'b0;
               clear   = 1'b1;
            end else if (word_valid) begin
               if (words_q[ADDR_W]) begin
                  // Memory full: drop the write and stall until restarted.
                  err_d = 1'b1;
               end else begin
                  mem_we  = 1'b1;
                  words_d = words_q + {{ADDR_W{1'b0}}, 1'b1};
                  if (bus.ld_last_i) state_d = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         words_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         words_q <= words_d;
         err_q   <= err_d;
      end
   end

   // Image storage; intentionally not cleared by reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[words_q[ADDR_W-1:0]] <= pack_word;
   end

   assign rd_idx          = bus.addr_i[ADDR_W+1:2];
   assign addr_lsb_unused = ^bus.addr_i[1:0];

   // Zero-latency fetch; only words of a completed image are visible.
   always_comb begin
      rd_data = NOP_WORD;
      if (bus.ce_i && (state_q == ST_IDLE) &&
          (bus.addr_i[INST_ADDR_BUS_W-1:ADDR_W+2] == '0) &&
          ({1'b0, rd_idx} < words_q)) begin
         rd_data = mem[rd_idx];
      end
   end

   assign bus.data_o      = rd_data;
   assign bus.ld_ready_o  = ready;
   assign bus.core_hold_o = (state_q != ST_IDLE);
   assign bus.ld_done_o   = (state_q == ST_DONE);
   assign bus.ld_err_o    = err_q;
   assign bus.words_o     = words_q;
endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: three instances (big-endian,
// little-endian, and a 4-word memory) share one stimulus stream.
module tb_inst_rom_loader;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce = 1'b1;
   logic [31:0] addr = 32'h0;
   logic        start = 1'b0;
   logic        valid = 1'b0;
   logic [7:0]  byte_v = 8'h0;
   logic        last = 1'b0;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   inst_rom_loader_if #(.ADDR_W(10)) if_a ();
   inst_rom_loader_if #(.ADDR_W(10)) if_b ();
   inst_rom_loader_if #(.ADDR_W(2))  if_c ();

   assign if_a.ce_i = ce;  assign if_a.addr_i = addr;  assign if_a.ld_start_i = start;
   assign if_a.ld_valid_i = valid;  assign if_a.ld_byte_i = byte_v;  assign if_a.ld_last_i = last;
   assign if_b.ce_i = ce;  assign if_b.addr_i = addr;  assign if_b.ld_start_i = start;
   assign if_b.ld_valid_i = valid;  assign if_b.ld_byte_i = byte_v;  assign if_b.ld_last_i = last;
   assign if_c.ce_i = ce;  assign if_c.addr_i = addr;  assign if_c.ld_start_i = start;
   assign if_c.ld_valid_i = valid;  assign if_c.ld_byte_i = byte_v;  assign if_c.ld_last_i = last;

   inst_rom_loader #(.ADDR_W(10), .BYTE_ORDER_BIG(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
   inst_rom_loader #(.ADDR_W(10), .BYTE_ORDER_BIG(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
   inst_rom_loader #(.ADDR_W(2),  .BYTE_ORDER_BIG(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Push expected fetch data, drive the address, then pop and compare.
   task automatic fetch(input string tag, input logic ce_v, input logic [31:0] a,
                        input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec);
      @(negedge clk);
      exp_q.push_back(ea);
      exp_q.push_back(eb);
      exp_q.push_back(ec);
      ce   = ce_v;
      addr = a;
      #1;
      chk({tag, "_a"}, if_a.data_o, exp_q.pop_front());
      chk({tag, "_b"}, if_b.data_o, exp_q.pop_front());
      chk({tag, "_c"}, if_c.data_o, exp_q.pop_front());
      ce   = 1'b1;
      addr = 32'h0;
   endtask

   task automatic start_load();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic put_byte(input logic [7:0] b, input logic l);
      @(negedge clk); valid = 1'b1; byte_v = b; last = l;
   endtask

   task automatic gap();
      @(negedge clk); valid = 1'b0; last = 1'b0;
   endtask

   initial begin
      // Reset state
      #1 rst = 1'b0;
      #2;
      chk("rst_words_a", 32'(if_a.words_o), 32'd0);
      chk("rst_words_c", 32'(if_c.words_o), 32'd0);
      chk("rst_err",     32'(if_a.ld_err_o), 32'd0);
      chk("rst_done",    32'(if_a.ld_done_o), 32'd0);
      chk("rst_hold",    32'(if_a.core_hold_o), 32'd0);
      chk("rst_ready",   32'(if_a.ld_ready_o), 32'd0);
      chk("rst_data",    if_a.data_o, 32'h0);
      @(negedge clk) rst = 1'b1;

      // 1: single word image
      start_load();
      #1;
      chk("t1_hold_load", 32'(if_a.core_hold_o), 32'd1);
      chk("t1_ready",     32'(if_a.ld_ready_o), 32'd1);
      put_byte(8'h34, 1'b0); put_byte(8'h02, 1'b0);
      put_byte(8'h00, 1'b0); put_byte(8'h01, 1'b1);
      gap(); #1;
      chk("t1_done",      32'(if_a.ld_done_o), 32'd1);
      chk("t1_hold_done", 32'(if_a.core_hold_o), 32'd1);
      chk("t1_words",     32'(if_a.words_o), 32'd1);
      chk("t1_data_busy", if_a.data_o, 32'h0);
      @(negedge clk); #1;
      chk("t1_done_off",  32'(if_a.ld_done_o), 32'd0);
      chk("t1_hold_off",  32'(if_a.core_hold_o), 32'd0);
      fetch("t1_w0", 1'b1, 32'h0, 32'h34020001, 32'h01000234, 32'h34020001);

      // 2: eight bytes with valid toggling
      start_load();
      for (int i = 0; i < 8; i++) begin
         put_byte(8'h11 + 8'(i), (i == 7));
         gap();
      end
      #1;
      chk("t2_done",    32'(if_a.ld_done_o), 32'd1);
      chk("t2_words_a", 32'(if_a.words_o), 32'd2);
      chk("t2_words_c", 32'(if_c.words_o), 32'd2);
      fetch("t2_a0",  1'b1, 32'h0,         32'h11121314, 32'h14131211, 32'h11121314);
      fetch("t2_a4",  1'b1, 32'h4,         32'h15161718, 32'h18171615, 32'h15161718);
      fetch("t2_a6",  1'b1, 32'h6,         32'h15161718, 32'h18171615, 32'h15161718);
      fetch("t2_a8",  1'b1, 32'h8,         32'h0, 32'h0, 32'h0);
      fetch("t2_hi",  1'b1, 32'h1000_0000, 32'h0, 32'h0, 32'h0);

      // 3: partial final word
      start_load();
      put_byte(8'hAA, 1'b0); put_byte(8'hBB, 1'b0); put_byte(8'hCC, 1'b0);
      put_byte(8'hDD, 1'b0); put_byte(8'hEE, 1'b1);
      gap(); #1;
      chk("t3_words_a", 32'(if_a.words_o), 32'd2);
      chk("t3_words_b", 32'(if_b.words_o), 32'd2);
      fetch("t3_w0", 1'b1, 32'h0, 32'hAABBCCDD, 32'hDDCCBBAA, 32'hAABBCCDD);
      fetch("t3_w1", 1'b1, 32'h4, 32'hEE000000, 32'h000000EE, 32'hEE000000);

      // 4: overflow of the 4-word instance
      start_load();
      for (int i = 0; i < 16; i++) put_byte(8'(i), 1'b0);
      gap(); #1;
      chk("t4_words16", 32'(if_c.words_o), 32'd4);
      chk("t4_err16",   32'(if_c.ld_err_o), 32'd0);
      chk("t4_ready16", 32'(if_c.ld_ready_o), 32'd1);
      put_byte(8'h10, 1'b1);
      gap(); #1;
      chk("t4_err",     32'(if_c.ld_err_o), 32'd1);
      chk("t4_ready",   32'(if_c.ld_ready_o), 32'd0);
      chk("t4_words",   32'(if_c.words_o), 32'd4);
      chk("t4_nodone",  32'(if_c.ld_done_o), 32'd0);
      chk("t4_hold",    32'(if_c.core_hold_o), 32'd1);
      chk("t4_words_a", 32'(if_a.words_o), 32'd5);
      chk("t4_done_a",  32'(if_a.ld_done_o), 32'd1);
      put_byte(8'h20, 1'b0);
      gap(); #1;
      chk("t4_ready_stuck", 32'(if_c.ld_ready_o), 32'd0);
      chk("t4_err_sticky",  32'(if_c.ld_err_o), 32'd1);
      start_load();
      #1;
      chk("t4_err_clr",   32'(if_c.ld_err_o), 32'd0);
      chk("t4_ready_clr", 32'(if_c.ld_ready_o), 32'd1);
      chk("t4_words_clr", 32'(if_c.words_o), 32'd0);

      // 5: reset asserted mid-load
      for (int i = 0; i < 6; i++) put_byte(8'h40 + 8'(i), 1'b0);
      @(negedge clk); valid = 1'b0; rst = 1'b0;
      #1;
      chk("t5_words_a", 32'(if_a.words_o), 32'd0);
      chk("t5_words_c", 32'(if_c.words_o), 32'd0);
      chk("t5_hold",    32'(if_a.core_hold_o), 32'd0);
      chk("t5_ready",   32'(if_a.ld_ready_o), 32'd0);
      @(negedge clk) rst = 1'b1;
      fetch("t5_a0", 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
      fetch("t5_a4", 1'b1, 32'h4, 32'h0, 32'h0, 32'h0);

      // 6: fetch disable, then restart colliding with a byte
      start_load();
      put_byte(8'hCA, 1'b0); put_byte(8'hFE, 1'b0);
      put_byte(8'hBA, 1'b0); put_byte(8'hBE, 1'b1);
      gap();
      @(negedge clk);
      fetch("t6_ce0", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      fetch("t6_ce1", 1'b1, 32'h0, 32'hCAFEBABE, 32'hBEBAFECA, 32'hCAFEBABE);
      start_load();
      put_byte(8'h01, 1'b0); put_byte(8'h02, 1'b0);
      put_byte(8'h03, 1'b0); put_byte(8'h04, 1'b0);
      gap(); #1;
      chk("t6_words1", 32'(if_a.words_o), 32'd1);
      @(negedge clk); start = 1'b1; valid = 1'b1; byte_v = 8'hFF;
      @(negedge clk); start = 1'b0; valid = 1'b0;
      #1;
      chk("t6_restart_a", 32'(if_a.words_o), 32'd0);
      chk("t6_restart_c", 32'(if_c.words_o), 32'd0);
      chk("t6_still_rdy", 32'(if_a.ld_ready_o), 32'd1);
      put_byte(8'h55, 1'b0); put_byte(8'h66, 1'b0);
      put_byte(8'h77, 1'b0); put_byte(8'h88, 1'b1);
      gap(); #1;
      chk("t6_done",  32'(if_a.ld_done_o), 32'd1);
      chk("t6_words", 32'(if_a.words_o), 32'd1);
      fetch("t6_w0", 1'b1, 32'h0, 32'h55667788, 32'h88776655, 32'h55667788);
      fetch("t6_w1", 1'b1, 32'h4, 32'h0, 32'h0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
